// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: skid-buffer state encoding
// and the default filler value presented by an empty stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // Replicated across the payload width to form the default NOP word.
    localparam logic NOP_BIT = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones,
// and returns to zero on clr (clr wins over inc).
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stage_register.sv
// Two-entry skid-buffer pipeline register with squash (flush), occupancy
// reporting and a saturating stall counter. Used for IF/ID, ID/EX, EX/MEM, MEM/WB.
module pipeline_stage_register
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{NOP_BIT}},
    parameter int               CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       dbg_state
);

    // Handshake: a beat moves when valid && ready at a rising edge. in_ready and
    // out_valid are decoded from registered state only, so neither depends
    // combinationally on the partner's signal; valid never waits on ready.

    pipe_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign dbg_state = state_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        main_d  = NOP_VALUE;
                        state_d = ST_EMPTY;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // Skid always holds the younger beat, so it refills main.
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    main_d  = NOP_VALUE;
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clock),
        .inc   (out_valid && !out_ready),
        .clr   (reset),
        .count (stall_count)
    );

endmodule
